// File: rtl/demux_pkg.sv
// Shared types for the registered 1:2 stream demultiplexer.
// Holds the holding-stage FSM state type and the default counter width.
package demux_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } demux_state_e;

   localparam int unsigned DEMUX_CNT_W_DEF = 16;

endpackage

// File: rtl/xfer_counter.sv
// Free-running transfer counter: adds one per cycle with inc high and
// wraps modulo 2^CNT_W.
module xfer_counter
   import demux_pkg::*;
#(
   parameter int unsigned CNT_W = DEMUX_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment on a transfer, natural wrap at the top.
   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 stream demultiplexer with one holding stage.
// A beat and its select bit are captured together; one cycle later the
// beat is offered on exactly one output. Only the selected consumer's
// ready can stall the input; the other ready is ignored.
// Optional per-output transfer counters are built when DEMUX_CNT_EN is
// defined; otherwise cnt0/cnt1 are tied to zero.
module demux1x2_reg
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = DEMUX_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   demux_state_e     state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;

   logic             sel_ready;
   logic             in_xfer;
   logic             out_xfer;

   // The held beat's consumer decides whether the stage can drain; this
   // is the only combinational path from inputs to outputs (in_ready).
   assign sel_ready = sel_q ? out1_ready : out0_ready;
   assign in_ready  = (state_q == EMPTY) | sel_ready;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = (state_q == FULL) & sel_ready;

   // Next-state: load on any input transfer (covers the EMPTY load and the
   // FULL drain-and-reload case), empty on a lone output transfer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (in_xfer) begin
         state_d = FULL;
         data_d  = in_data;
         sel_d   = in_sel;
      end else if (out_xfer) begin
         state_d = EMPTY;
      end
   end

   // Holding-stage registers; reset discards any held beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign out0_valid = (state_q == FULL) & ~sel_q;
   assign out1_valid = (state_q == FULL) &  sel_q;
   assign out0_data  = data_q;
   assign out1_data  = data_q;

`ifdef DEMUX_CNT_EN
   logic out0_xfer;
   logic out1_xfer;

   assign out0_xfer = out0_valid & out0_ready;
   assign out1_xfer = out1_valid & out1_ready;

   xfer_counter #(.CNT_W(CNT_W)) u_cnt0 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out0_xfer),
      .count (cnt0)
   );

   xfer_counter #(.CNT_W(CNT_W)) u_cnt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out1_xfer),
      .count (cnt1)
   );
`else
   assign cnt0 = '0;
   assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1x2_reg.sv
// Directed bench for demux1x2_reg. Inputs change and outputs are sampled
// on the falling clock edge; the design acts on the rising edge.
module tb_demux1x2_reg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   int unsigned n_checks;
   int unsigned n_errors;

   demux1x2_reg #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected counter value after n transfers for this build.
   function automatic logic [31:0] cexp(input int unsigned n);
`ifdef DEMUX_CNT_EN
      return 32'(n % (1 << CNT_W));
`else
      return 32'(0 * n);
`endif
   endfunction

   // Check which output holds beat k: odd -> out0, even -> out1.
   task automatic check_beat(input int unsigned k);
      if (k % 2 == 1) begin
         check_eq("stream_o0v", 32'(out0_valid), 32'd1);
         check_eq("stream_o0d", 32'(out0_data), 32'(k));
         check_eq("stream_o1v", 32'(out1_valid), 32'd0);
      end else begin
         check_eq("stream_o1v", 32'(out1_valid), 32'd1);
         check_eq("stream_o1d", 32'(out1_data), 32'(k));
         check_eq("stream_o0v", 32'(out0_valid), 32'd0);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      in_data    = 8'h55;
      in_sel     = 1'b1;
      in_valid   = 1'b1;
      out0_ready = 1'b0;
      out1_ready = 1'b0;

      // Reset held with a beat offered: nothing may be captured.
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_o0v", 32'(out0_valid), 32'd0);
      check_eq("rst_o1v", 32'(out1_valid), 32'd0);
      check_eq("rst_o0d", 32'(out0_data), 32'd0);
      check_eq("rst_o1d", 32'(out1_data), 32'd0);
      check_eq("rst_cnt0", 32'(cnt0), 32'd0);
      check_eq("rst_cnt1", 32'(cnt1), 32'd0);

      // Release: beat 0x55 to out1 is taken at the very next edge.
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("first_o1v", 32'(out1_valid), 32'd1);
      check_eq("first_o1d", 32'(out1_data), 32'h55);
      check_eq("first_o0v", 32'(out0_valid), 32'd0);
      check_eq("first_in_ready", 32'(in_ready), 32'd0);
      in_valid   = 1'b0;
      out1_ready = 1'b1;
      @(negedge clk);
      check_eq("first_drain", 32'(out1_valid), 32'd0);
      check_eq("first_cnt1", 32'(cnt1), cexp(1));

      // Single beat 0xA5 to out0.
      out1_ready = 1'b0;
      out0_ready = 1'b1;
      in_data    = 8'hA5;
      in_sel     = 1'b0;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("single_o0v", 32'(out0_valid), 32'd1);
      check_eq("single_o0d", 32'(out0_data), 32'hA5);
      check_eq("single_o1v", 32'(out1_valid), 32'd0);
      @(negedge clk);
      check_eq("single_empty0", 32'(out0_valid), 32'd0);
      check_eq("single_empty1", 32'(out1_valid), 32'd0);
      check_eq("single_cnt0", 32'(cnt0), cexp(1));

      // Streaming 1..8, odd to out0 and even to out1, no bubbles.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int unsigned i = 1; i <= 8; i++) begin
         if (i > 1) check_beat(i - 1);
         in_data  = 8'(i);
         in_sel   = (i % 2 == 0);
         in_valid = 1'b1;
         #1;
         check_eq("stream_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      check_beat(8);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("stream_end0", 32'(out0_valid), 32'd0);
      check_eq("stream_end1", 32'(out1_valid), 32'd0);
      check_eq("stream_cnt0", 32'(cnt0), cexp(5));
      check_eq("stream_cnt1", 32'(cnt1), cexp(5));

      // Backpressure on out1 while out0 is ready and a second beat waits.
      out1_ready = 1'b0;
      out0_ready = 1'b1;
      in_data    = 8'h3C;
      in_sel     = 1'b1;
      in_valid   = 1'b1;
      @(negedge clk);
      in_data = 8'h77;
      in_sel  = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         #1;
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         check_eq("bp_o1v", 32'(out1_valid), 32'd1);
         check_eq("bp_o1d", 32'(out1_data), 32'h3C);
         check_eq("bp_o0v", 32'(out0_valid), 32'd0);
         @(negedge clk);
      end
      out1_ready = 1'b1;
      #1;
      check_eq("bp_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("bp_next_o0v", 32'(out0_valid), 32'd1);
      check_eq("bp_next_o0d", 32'(out0_data), 32'h77);
      check_eq("bp_next_o1v", 32'(out1_valid), 32'd0);
      @(negedge clk);
      check_eq("bp_drain", 32'(out0_valid), 32'd0);
      check_eq("bp_cnt0", 32'(cnt0), cexp(6));
      check_eq("bp_cnt1", 32'(cnt1), cexp(6));

      // Asynchronous reset while FULL.
      out1_ready = 1'b0;
      in_data    = 8'h99;
      in_sel     = 1'b1;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("ar_full", 32'(out1_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar_o1v", 32'(out1_valid), 32'd0);
      check_eq("ar_o1d", 32'(out1_data), 32'd0);
      check_eq("ar_cnt0", 32'(cnt0), 32'd0);
      check_eq("ar_cnt1", 32'(cnt1), 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      out1_ready = 1'b1;
      @(negedge clk);
      check_eq("ar_no_stale1", 32'(out1_valid), 32'd0);
      check_eq("ar_no_stale0", 32'(out0_valid), 32'd0);

      // Counter wrap: 17 beats to out0, 3 to out1.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int unsigned i = 0; i < 20; i++) begin
         in_data  = 8'(8'hC0 + i);
         in_sel   = (i >= 17);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("wrap_cnt0", 32'(cnt0), cexp(17));
      check_eq("wrap_cnt1", 32'(cnt1), cexp(3));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
